tx_fsm: RTL and testbench
=========================

Name: tx_fsm

Overview:
- Transmit-direction FSM of the serial full-duplex module; the counterpart of the receive FSM.
- On a TX request from the top-level controller it:
  - captures a 2**DATA_WIDTH_BASE-bit word;
  - shifts the word out on data_tx with an sck_tx strobe per bit;
  - pulses latch_tx so the external shift register transfers the word to its outputs;
  - reports completion with finish and finish_fsm, using the same handshake as the receive FSM.

Parameters:
- DATA_WIDTH_BASE, 5: word width W = 2**DATA_WIDTH_BASE (default 32).
- FINISH_DELAY, 5: number of cycles finish stays high before the finish_fsm pulse (range 1..2**DATA_WIDTH_BASE).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- state_in  in  2  top-level mode: 0 idle, 1 RX, 2 TX, 3 reserved.
- transmit_data  in  W  parallel word; sampled only in LOAD.
- data_tx  out  1  serial data to external shift register.
- sck_tx  out  1  shift clock; external device samples data_tx on its rising edge.
- latch_tx  out  1  storage-register latch pulse.
- busy  out  1  high in every state except IDLE.
- finish  out  1  high throughout FINISH.
- finish_fsm  out  1  one-cycle end pulse back to the controller.

Behaviour:
- Reset is asynchronous and active-low. While rst=0:
  - state=IDLE;
  - data_tx, sck_tx, latch_tx, busy, finish, finish_fsm = 0;
  - shift register and counter cleared.
- Outputs are registered: each is decoded from next_state, so it is valid for exactly the cycles the state register holds the matching state. No combinational outputs.
- States and transitions:
  - IDLE: go to LOAD when state_in==2; stay otherwise. Values 1 and 3 are ignored.
  - LOAD (1 cycle): shreg<=transmit_data; bit counter cnt<=W-1 (width DATA_WIDTH_BASE); busy<=1; go to SETUP.
  - SETUP (1 cycle): data_tx<=shreg[0]; sck_tx=0.
  - SCK_HI (1 cycle): sck_tx=1; data_tx held.
  - SCK_LO (1 cycle): sck_tx=0; shreg shifts right by one.
    - cnt!=0: cnt<=cnt-1, go to SETUP.
    - cnt==0: go to LATCH_HI.
  - LATCH_HI (1 cycle): latch_tx=1; data_tx<=0.
  - LATCH_LO (1 cycle): latch_tx=0; delay counter<=0.
  - FINISH: finish=1; delay counter increments; stay FINISH_DELAY cycles, then go to END_PULSE.
  - END_PULSE (1 cycle): finish=0, finish_fsm=1; go to IDLE. In IDLE, finish_fsm=0 and busy=0.
- Timing:
  - Each bit takes 3 cycles, so W bits take 3W cycles.
  - Frame length from first LOAD cycle to last END_PULSE cycle = 1 + 3W + 2 + FINISH_DELAY + 1; W=32, FINISH_DELAY=5 gives 105 cycles.
  - data_tx is stable 1 cycle before and through each sck_tx high cycle (setup and hold of 1 clk each).
- Boundary conditions:
  - state_in is sampled only in IDLE. Changes mid-frame, including to 1 or 0, are ignored and the frame completes.
  - transmit_data changes after LOAD have no effect on the current frame.
  - state_in still 2 when END_PULSE returns to IDLE: a new frame starts the next cycle (back-to-back frames allowed, 1 IDLE cycle between frames).
  - Reset asserted mid-frame: outputs drop to 0 immediately (asynchronously); no latch_tx or finish pulse is emitted afterwards.
  - Counter wrap: cnt is never decremented below 0; the cnt==0 check precedes the decrement.
- sck_tx and latch_tx are never high in the same cycle.

Optional Feature:
- Macro: TX_MSB_FIRST_EN.
- Defined: LOAD is unchanged; SETUP drives shreg[W-1]; SCK_LO shifts left.
- Undefined (default): LSB first, matching the receive FSM's shift order.
- Cycle timing is identical in both builds.

Decomposition:
- Shared header serial_defs.vh holds:
  - mode encodings MODE_IDLE=2'd0, MODE_RX=2'd1, MODE_TX=2'd2;
  - tx state codes as localparam-style defines (4-bit: 9 states).
- One natural sub-module: tx_shift_reg, holding:
  - W-bit load/shift register with a serial-out bit;
  - direction selected by TX_MSB_FIRST_EN;
  - ports clk, rst, load, shift, din, sout.
- The FSM, bit counter and delay counter stay in tx_fsm.

Test Plan:
- Reset values: hold rst=0 for 3 cycles with state_in=2 -> all outputs 0; 1 cycle after release, busy=1.
- LSB-first frame: transmit_data=32'hA5A50F01, state_in=2 for one cycle -> bits sampled on sck_tx rising edges are 1,0,0,0,0,0,0,0,1,1,1,1,0,0,0,0,1,0,1,0,0,1,0,1,1,0,1,0,0,1,0,1. Also check 32 sck_tx pulses, one latch_tx pulse 2 cycles after the last sck_tx high, finish high 5 cycles, finish_fsm 1 cycle, 105 busy cycles total.
- Mid-frame changes: state_in changed to 1 after bit 10 and transmit_data changed to 0 mid-frame -> serial stream identical to the previous test; frame completes normally.
- Back-to-back frames: state_in held at 2, data 32'hFFFFFFFF then 32'h00000000 -> two frames separated by exactly 1 IDLE cycle; second frame outputs all zeros.
- Reset abort: rst pulsed low during SCK_HI of bit 5 -> sck_tx and busy fall without waiting for a clock edge; no latch_tx, finish or finish_fsm pulse until a new request.
- MSB-first build: TX_MSB_FIRST_EN defined, data 32'h80000001 -> first sampled bit 1, then 30 zeros, then 1; same 105-cycle frame length.

Source files
------------

// File: rtl/tx_fsm_pkg.sv
// Shared encodings for the serial TX path: controller mode codes and TX FSM state codes.
package tx_fsm_pkg;

    localparam logic [1:0] MODE_IDLE = 2'd0;
    localparam logic [1:0] MODE_RX   = 2'd1;
    localparam logic [1:0] MODE_TX   = 2'd2;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_LOAD      = 4'd1,
        ST_SETUP     = 4'd2,
        ST_SCK_HI    = 4'd3,
        ST_SCK_LO    = 4'd4,
        ST_LATCH_HI  = 4'd5,
        ST_LATCH_LO  = 4'd6,
        ST_FINISH    = 4'd7,
        ST_END_PULSE = 4'd8
    } tx_state_t;

endpackage

// File: rtl/tx_shift_reg.sv
// W-bit parallel-load / serial-out register; load has priority over shift, sout is the next bit to send.
// Shift order: LSB first by default, MSB first when TX_MSB_FIRST_EN is defined.
module tx_shift_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         sout
);

    logic [W-1:0] shreg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg <= '0;
        end else if (load) begin
            shreg <= din;
        end else if (shift) begin
`ifdef TX_MSB_FIRST_EN
            shreg <= {shreg[W-2:0], 1'b0};
`else
            shreg <= {1'b0, shreg[W-1:1]};
`endif
        end
    end

`ifdef TX_MSB_FIRST_EN
    assign sout = shreg[W-1];
`else
    assign sout = shreg[0];
`endif

endmodule

// File: rtl/tx_fsm.sv
// Transmit FSM: loads a word, shifts it out with one sck_tx strobe per bit, pulses latch_tx, then finish/finish_fsm.
// Frame is 1 + 3W + 2 + FINISH_DELAY + 1 cycles; all outputs registered. Optional macro: TX_MSB_FIRST_EN.
module tx_fsm
    import tx_fsm_pkg::*;
#(
    parameter int DATA_WIDTH_BASE = 5,
    parameter int FINISH_DELAY    = 5
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [1:0]                      state_in,
    input  logic [(2**DATA_WIDTH_BASE)-1:0] transmit_data,
    output logic                            data_tx,
    output logic                            sck_tx,
    output logic                            latch_tx,
    output logic                            busy,
    output logic                            finish,
    output logic                            finish_fsm
);

    localparam int W     = 2**DATA_WIDTH_BASE;
    localparam int CNT_W = DATA_WIDTH_BASE;
    localparam int DLY_W = DATA_WIDTH_BASE + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(FINISH_DELAY - 1);

    tx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic             data_d;
    logic             sout;
    logic             sh_load;
    logic             sh_shift;

    // Register-side actions are keyed on the state being entered, so the shift
    // register already holds the right bit when SETUP copies it to data_tx.
    assign sh_load  = (state_d == ST_LOAD);
    assign sh_shift = (state_d == ST_SCK_LO);

    tx_shift_reg #(
        .W (W)
    ) u_shreg (
        .clk   (clk),
        .rst   (rst),
        .load  (sh_load),
        .shift (sh_shift),
        .din   (transmit_data),
        .sout  (sout)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dly_d   = dly_q;
        data_d  = data_tx;

        case (state_q)
            ST_IDLE:     if (state_in == MODE_TX) state_d = ST_LOAD;
            ST_LOAD:     state_d = ST_SETUP;
            ST_SETUP:    state_d = ST_SCK_HI;
            ST_SCK_HI:   state_d = ST_SCK_LO;
            ST_SCK_LO: begin
                // Zero test comes first so the counter never wraps.
                if (cnt_q != '0) begin
                    cnt_d   = cnt_q - 1'b1;
                    state_d = ST_SETUP;
                end else begin
                    state_d = ST_LATCH_HI;
                end
            end
            ST_LATCH_HI: state_d = ST_LATCH_LO;
            ST_LATCH_LO: begin
                dly_d   = '0;
                state_d = ST_FINISH;
            end
            ST_FINISH: begin
                if (dly_q == DLY_LAST) state_d = ST_END_PULSE;
                else                   dly_d   = dly_q + 1'b1;
            end
            ST_END_PULSE: state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase

        if (state_d == ST_LOAD) cnt_d = CNT_LAST;

        if (state_d == ST_SETUP)         data_d = sout;
        else if (state_d == ST_LATCH_HI) data_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            dly_q      <= '0;
            data_tx    <= 1'b0;
            sck_tx     <= 1'b0;
            latch_tx   <= 1'b0;
            busy       <= 1'b0;
            finish     <= 1'b0;
            finish_fsm <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dly_q      <= dly_d;
            data_tx    <= data_d;
            sck_tx     <= (state_d == ST_SCK_HI);
            latch_tx   <= (state_d == ST_LATCH_HI);
            busy       <= (state_d != ST_IDLE);
            finish     <= (state_d == ST_FINISH);
            finish_fsm <= (state_d == ST_END_PULSE);
        end
    end

endmodule

// File: tb/tb_tx_fsm.sv
// Directed bench for tx_fsm: reset, LSB/MSB stream order, frame timing, mid-frame changes, back-to-back, reset abort.
module tb_tx_fsm;
    import tx_fsm_pkg::*;

    logic        clk;
    logic        rst;
    logic [1:0]  state_in;
    logic [31:0] transmit_data;
    logic        data_tx;
    logic        sck_tx;
    logic        latch_tx;
    logic        busy;
    logic        finish;
    logic        finish_fsm;

    int n_assert = 0;
    int n_fail   = 0;

    tx_fsm #(
        .DATA_WIDTH_BASE (5),
        .FINISH_DELAY    (5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .state_in      (state_in),
        .transmit_data (transmit_data),
        .data_tx       (data_tx),
        .sck_tx        (sck_tx),
        .latch_tx      (latch_tx),
        .busy          (busy),
        .finish        (finish),
        .finish_fsm    (finish_fsm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts a frame from IDLE (called at a falling edge) and watches it until busy drops.
    task automatic run_frame(input string tag, input logic [31:0] data, input logic [1:0] hold_state,
                             input int chg_bit, input logic [1:0] chg_state, input logic [31:0] chg_data);
        logic [31:0] got, exp_s;
        int nb, nlatch, overlap, setup_err, nfin, nff, cyc;
        int last_sck, latch_at, fin_last, ff_at;
        logic prev_sck, prev_latch, prev_dat, chg_done;
        got = '0; nb = 0; nlatch = 0; overlap = 0; setup_err = 0; nfin = 0; nff = 0; cyc = 0;
        last_sck = -1; latch_at = -1; fin_last = -1; ff_at = -1;
        prev_sck = 1'b0; prev_latch = 1'b0; prev_dat = 1'b0; chg_done = 1'b0;
        for (int i = 0; i < 32; i++) begin
`ifdef TX_MSB_FIRST_EN
            exp_s[i] = data[31-i];
`else
            exp_s[i] = data[i];
`endif
        end

        transmit_data = data;
        state_in      = MODE_TX;
        @(negedge clk);
        check({tag, "_start_busy"}, busy, 1);
        state_in = hold_state;

        while (busy === 1'b1 && cyc < 400) begin
            if (sck_tx && !prev_sck) begin
                if (nb < 32) got[nb] = data_tx;
                if (data_tx !== prev_dat) setup_err++;
                nb++;
                last_sck = cyc;
            end
            if (!sck_tx && prev_sck && data_tx !== prev_dat) setup_err++;
            if (latch_tx && !prev_latch) begin
                nlatch++;
                latch_at = cyc;
            end
            if (sck_tx && latch_tx) overlap++;
            if (finish) begin
                nfin++;
                fin_last = cyc;
            end
            if (finish_fsm) begin
                nff++;
                ff_at = cyc;
            end
            prev_sck   = sck_tx;
            prev_latch = latch_tx;
            prev_dat   = data_tx;
            if (nb == chg_bit && !chg_done) begin
                state_in      = chg_state;
                transmit_data = chg_data;
                chg_done      = 1'b1;
            end
            cyc++;
            @(negedge clk);
        end

        check({tag, "_end_busy"},      busy,             0);
        check({tag, "_stream"},        got,              exp_s);
        check({tag, "_sck_pulses"},    nb,               32);
        check({tag, "_latch_pulses"},  nlatch,           1);
        check({tag, "_latch_gap"},     latch_at - last_sck, 2);
        check({tag, "_sck_latch_ovl"}, overlap,          0);
        check({tag, "_setup_hold"},    setup_err,        0);
        check({tag, "_finish_cycles"}, nfin,             5);
        check({tag, "_fin_fsm_cycles"}, nff,             1);
        check({tag, "_fin_then_end"},  ff_at - fin_last, 1);
        check({tag, "_busy_cycles"},   cyc,              105);
    endtask

    initial begin
        int nb;
        int bad;
        logic prev;

        rst           = 1'b0;
        state_in      = MODE_TX;
        transmit_data = 32'hA5A50F01;
        repeat (3) @(negedge clk);
        check("rst_data_tx",    data_tx,    0);
        check("rst_sck_tx",     sck_tx,     0);
        check("rst_latch_tx",   latch_tx,   0);
        check("rst_busy",       busy,       0);
        check("rst_finish",     finish,     0);
        check("rst_finish_fsm", finish_fsm, 0);
        rst = 1'b1;
        @(negedge clk);
        check("busy_after_release", busy, 1);
        rst      = 1'b0;
        state_in = MODE_IDLE;
        #1;
        check("busy_async_clear", busy, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        run_frame("lsb", 32'hA5A50F01, MODE_IDLE, -1, MODE_IDLE, 32'h0);

        run_frame("mid", 32'hA5A50F01, MODE_TX, 11, MODE_RX, 32'h0);
        repeat (4) @(negedge clk);
        check("mid_no_restart", busy, 0);

        run_frame("b2b_a", 32'hFFFFFFFF, MODE_TX, -1, MODE_IDLE, 32'h0);
        run_frame("b2b_b", 32'h00000000, MODE_IDLE, -1, MODE_IDLE, 32'h0);

        run_frame("msb_pat", 32'h80000001, MODE_IDLE, -1, MODE_IDLE, 32'h0);

        // Abort during SCK_HI of bit 5.
        transmit_data = 32'h0000FFFF;
        state_in      = MODE_TX;
        @(negedge clk);
        state_in = MODE_IDLE;
        nb   = 0;
        prev = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (sck_tx && !prev) nb++;
            prev = sck_tx;
            if (nb == 6) break;
            @(negedge clk);
        end
        check("abort_reached_bit5", nb, 6);
        check("abort_sck_before", sck_tx, 1);
        #1 rst = 1'b0;
        #1;
        check("abort_sck_async", sck_tx, 0);
        check("abort_busy_async", busy, 0);
        check("abort_data_async", data_tx, 0);
        #1 rst = 1'b1;
        bad = 0;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            if (latch_tx || finish || finish_fsm || busy || sck_tx) bad++;
        end
        check("abort_quiet_after", bad, 0);

        run_frame("recover", 32'h12345678, MODE_IDLE, -1, MODE_IDLE, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
